// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, bus widths
// and the access-error rule.
package dmem_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFFS_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // A word access is illegal when misaligned or beyond the last stored word;
  // idx_w is the word-index width, so any set bit above it is out of range.
  function automatic logic addr_error(input logic [WORD_W-1:0] addr,
                                      input int unsigned      idx_w);
    return (addr[OFFS_W-1:0] != '0) || ((addr >> (idx_w + OFFS_W)) != '0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage with one synchronous write port and one registered read port.
// The read register doubles as the response data holder, so it can also be
// cleared and is reset; the storage itself is never reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX         = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [IDX-1:0]    idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Registered read / clear of the response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory interface: accepts one word load/store,
// executes it after LATENCY busy cycles and holds the response until taken.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX   = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic              write_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              resp_valid_q;
  logic              resp_error_q;

  logic              req_ready;
  logic              accept;
  logic              handoff;
  logic              execute;
  logic              err;
  logic              arr_we;
  logic              arr_re;
  logic              arr_clr;

  // Ready depends on resp_ready so a response handoff and the next accept
  // can share one edge without an IDLE bubble.
  assign req_ready = (state == IDLE) || ((state == RESP) && bus.resp_ready);
  assign accept    = bus.req_valid && req_ready;
  assign handoff   = (state == RESP) && bus.resp_ready;
  assign execute   = (state == BUSY) && (count == '0);
  assign err       = addr_error(addr_q, IDX);

  // The op executes in the array on the same edge the FSM enters RESP.
  assign arr_we  = execute && write_q && !err;
  assign arr_re  = execute && !write_q && !err;
  assign arr_clr = (execute && (write_q || err)) || handoff;

  // Control FSM with request capture and registered response flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            count   <= CNT_W'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (count == '0) begin
            resp_valid_q <= 1'b1;
            resp_error_q <= err;
            state        <= RESP;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        RESP: begin
          if (handoff) begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            if (bus.req_valid) begin
              write_q <= bus.req_write;
              addr_q  <= bus.req_addr;
              wdata_q <= bus.req_wdata;
              count   <= CNT_W'(LATENCY - 1);
              state   <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX         (IDX)
  ) u_array (
    .clk   (clk),
    .rst_n (reset),
    .we    (arr_we),
    .re    (arr_re),
    .clr   (arr_clr),
    .idx   (addr_q[IDX+OFFS_W-1:OFFS_W]),
    .wdata (wdata_q),
    .rdata (bus.resp_rdata)
  );

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_error = resp_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance for functional,
// hold and reset scenarios and a LATENCY=1 instance for streaming throughput.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          gap;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int prev1    = 0;

  exp_t q2[$];
  exp_t q1[$];
  exp_t e2;
  exp_t e1;

  logic [31:0] tbl_a [8];
  logic [31:0] tbl_d [8];

  dmem_responder_if b2();
  dmem_responder_if b1();

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2.slave)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Scoreboard monitor for the LATENCY=2 instance.
  always @(negedge clk) begin
    if (reset && b2.resp_valid && b2.resp_ready) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut2_unexpected_resp: got rdata %h error %b, required no response",
                 b2.resp_rdata, b2.resp_error);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_rdata", b2.resp_rdata, e2.rdata);
        chk("dut2_error", {31'b0, b2.resp_error}, {31'b0, e2.err});
      end
    end
  end

  // Scoreboard monitor for the LATENCY=1 instance, including response spacing.
  always @(negedge clk) begin
    if (reset && b1.resp_valid && b1.resp_ready) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_unexpected_resp: got rdata %h error %b, required no response",
                 b1.resp_rdata, b1.resp_error);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_rdata", b1.resp_rdata, e1.rdata);
        chk("dut1_error", {31'b0, b1.resp_error}, {31'b0, e1.err});
        if (e1.gap) chk("dut1_gap", 32'(cyc - prev1), 32'd2);
      end
      prev1 = cyc;
    end
  end

  // Present a request on the LATENCY=2 bus and return 1 ns after its accept edge.
  task automatic issue2(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee, input bit push);
    int n = 0;
    b2.req_valid = 1'b1;
    b2.req_write = w;
    b2.req_addr  = a;
    b2.req_wdata = d;
    forever begin
      @(negedge clk);
      if (b2.req_ready) break;
      n++;
      if (n > 50) begin
        timeout("dut2_accept");
        break;
      end
    end
    @(posedge clk);
    if (push) q2.push_back('{er, ee, 1'b0});
    #1;
    b2.req_valid = 1'b0;
  endtask

  task automatic wait_valid2(output int n);
    n = 0;
    while (!b2.resp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!b2.resp_valid) timeout("dut2_resp_valid");
  endtask

  task automatic drain2();
    int n = 0;
    while (q2.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset2(input string tag);
    chk({tag, "_req_ready"},  {31'b0, b2.req_ready},  32'd1);
    chk({tag, "_resp_valid"}, {31'b0, b2.resp_valid}, 32'd0);
    chk({tag, "_resp_rdata"}, b2.resp_rdata,          32'd0);
    chk({tag, "_resp_error"}, {31'b0, b2.resp_error}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl_a[0] = 32'h0000_0040; tbl_d[0] = 32'h0102_0304;
    tbl_a[1] = 32'h0000_0044; tbl_d[1] = 32'h1111_0001;
    tbl_a[2] = 32'h0000_0048; tbl_d[2] = 32'h2222_0002;
    tbl_a[3] = 32'h0000_004C; tbl_d[3] = 32'h3333_0003;
    tbl_a[4] = 32'h0000_03F0; tbl_d[4] = 32'hCAFE_F00D;
    tbl_a[5] = 32'h0000_03F4; tbl_d[5] = 32'h8000_0000;
    tbl_a[6] = 32'h0000_03F8; tbl_d[6] = 32'h0000_0001;
    tbl_a[7] = 32'h0000_03FC; tbl_d[7] = 32'hFFFF_FFFF;

    reset = 1'b0;
    b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = '0; b2.req_wdata = '0;
    b2.resp_ready = 1'b1;
    b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
    b1.resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    chk_reset2("por");
    chk("por_dut1_req_ready",  {31'b0, b1.req_ready},  32'd1);
    chk("por_dut1_resp_valid", {31'b0, b1.resp_valid}, 32'd0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Store then load at 0x10, with accept-to-valid latency check.
    issue2(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    wait_valid2(n);
    chk("store_latency_edges", 32'(n), 32'd2);
    issue2(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);

    // Error cases; 0x400 would alias word 0 if the range check were missing.
    issue2(1'b1, 32'h0000_0000, 32'hA5A5_0000, 32'h0, 1'b0, 1'b1);
    issue2(1'b0, 32'h0000_0013, 32'h0, 32'h0, 1'b1, 1'b1);
    issue2(1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    issue2(1'b1, 32'hFFFF_FFFC, 32'h7777_7777, 32'h0, 1'b1, 1'b1);
    issue2(1'b0, 32'h0000_0000, 32'h0, 32'hA5A5_0000, 1'b0, 1'b1);
    issue2(1'b0, 32'h0000_03FC, 32'h0, 32'h0, 1'b0, 1'b0);
    q2.push_back('{32'h0, 1'b0, 1'b0});
    drain2();
    issue2(1'b1, 32'h0000_03FC, 32'h5555_AAAA, 32'h0, 1'b0, 1'b1);
    issue2(1'b0, 32'h0000_03FC, 32'h0, 32'h5555_AAAA, 1'b0, 1'b1);
    issue2(1'b0, 32'h0000_0402, 32'h0, 32'h0, 1'b1, 1'b1);

    // Response held while resp_ready is low, then handoff with same-edge accept.
    drain2();
    b2.resp_ready = 1'b0;
    issue2(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    wait_valid2(n);
    repeat (5) begin
      @(negedge clk);
      chk("hold_resp_valid", {31'b0, b2.resp_valid}, 32'd1);
      chk("hold_resp_rdata", b2.resp_rdata, 32'hDEAD_BEEF);
      chk("hold_req_ready",  {31'b0, b2.req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    b2.req_valid = 1'b1; b2.req_write = 1'b0; b2.req_addr = 32'h0; b2.req_wdata = '0;
    b2.resp_ready = 1'b1;
    @(negedge clk);
    chk("handoff_req_ready", {31'b0, b2.req_ready}, 32'd1);
    @(posedge clk);
    q2.push_back('{32'hA5A5_0000, 1'b0, 1'b0});
    #1;
    chk("handoff_resp_valid", {31'b0, b2.resp_valid}, 32'd0);
    chk("handoff_resp_rdata", b2.resp_rdata, 32'd0);
    chk("handoff_req_ready_busy", {31'b0, b2.req_ready}, 32'd0);
    b2.req_valid = 1'b0;

    // Reset while BUSY aborts the pending store.
    drain2();
    issue2(1'b1, 32'h0000_0020, 32'h1111_2222, 32'h0, 1'b0, 1'b1);
    drain2();
    issue2(1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 chk_reset2("busy_rst");
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    issue2(1'b0, 32'h0000_0020, 32'h0, 32'h1111_2222, 1'b0, 1'b1);

    // Reset while a response is held in RESP.
    drain2();
    b2.resp_ready = 1'b0;
    issue2(1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 1'b0);
    wait_valid2(n);
    #2 reset = 1'b0;
    #1 chk_reset2("resp_rst");
    #1 reset = 1'b1;
    b2.resp_ready = 1'b1;
    @(posedge clk);
    #1;

    // LATENCY=1 stream: 8 stores then 8 loads, req_valid held high throughout.
    for (int i = 0; i < 16; i++) begin
      int k = 0;
      b1.req_valid = 1'b1;
      b1.req_write = (i < 8);
      b1.req_addr  = tbl_a[i % 8];
      b1.req_wdata = (i < 8) ? tbl_d[i % 8] : 32'h0;
      forever begin
        @(negedge clk);
        if (b1.req_ready) break;
        k++;
        if (k > 50) begin
          timeout("dut1_accept");
          break;
        end
      end
      @(posedge clk);
      q1.push_back('{(i < 8) ? 32'h0 : tbl_d[i % 8], 1'b0, (i != 0)});
      #1;
    end
    b1.req_valid = 1'b0;

    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("dut2_queue_drained", 32'(q2.size()), 32'd0);
    chk("dut1_queue_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
